data_req_queue: RTL and testbench

Parametrised data-memory request controller for the EXE/MEM boundary. It replaces the single-request IDLE/ADDROK/DATAOK handshake with up to `OUTSTANDING` pipelined loads and stores on the SRAM-like `data_sram_*` interface. It also owns a response FIFO and a flush path that cancels in-flight accesses after an exception or ertn. It accepts already-translated physical addresses and produces in-order responses for the MEM stage.

---
 rtl/data_req_queue_pkg.sv | 48 ++++
 rtl/data_req_queue_rsp_fifo.sv | 63 ++++++
 rtl/data_req_queue.sv | 163 ++++++++++++++++
 tb/tb_data_req_queue.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_req_queue_pkg.sv
// Shared encodings and helpers for the pipelined data-memory request queue.
package data_req_queue_pkg;

  localparam logic [1:0] MEMSZ_B = 2'd0;
  localparam logic [1:0] MEMSZ_H = 2'd1;
  localparam logic [1:0] MEMSZ_W = 2'd2;

  localparam logic [1:0] StIdle      = 2'd0;
  localparam logic [1:0] StIssue     = 2'd1;
  localparam logic [1:0] StIssueKill = 2'd2;

  typedef struct packed {
    logic       wr;
    logic [1:0] size;
    logic [1:0] addr_lo;
  } req_meta_t;

  typedef struct packed {
    req_meta_t   meta;
    logic [31:0] rdata;
  } rsp_t;

  function automatic logic calc_ale(input logic [1:0] size, input logic [1:0] addr_lo);
    return ((size == MEMSZ_H) & addr_lo[0]) | ((size == MEMSZ_W) & (addr_lo != 2'b00));
  endfunction

  function automatic logic [3:0] calc_wstrb(input logic wr, input logic [1:0] size,
                                            input logic [1:0] addr_lo);
    logic [3:0] strb;
    case (size)
      MEMSZ_B: strb = 4'b0001 << addr_lo;
      MEMSZ_H: strb = addr_lo[1] ? 4'b1100 : 4'b0011;
      default: strb = 4'b1111;
    endcase
    return wr ? strb : 4'b0000;
  endfunction

  function automatic logic [31:0] align_wdata(input logic [1:0] size, input logic [31:0] wdata);
    logic [31:0] res;
    case (size)
      MEMSZ_B: res = {4{wdata[7:0]}};
      MEMSZ_H: res = {2{wdata[15:0]}};
      default: res = wdata;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/data_req_queue_rsp_fifo.sv
// Small synchronous FIFO with a single-cycle clear; one push and one pop per cycle.
module rsp_fifo #(
  parameter int unsigned WIDTH = 37,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(DEPTH - 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             full, do_push, do_pop;

  assign full    = (cnt_q == FullCnt);
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i & ~full;
  assign do_pop  = pop_i & ~empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
      cnt_d = cnt_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push & ~clear_i) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/data_req_queue.sv
// EXE/MEM data request controller: pipelined SRAM-like issue, in-order responses,
// and flush handling that drains cancelled accesses still on the bus.
module data_req_queue
  import data_req_queue_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned OUTSTANDING = 2,
  parameter int unsigned CNT_W       = $clog2(OUTSTANDING + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [1:0]        req_size,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              req_ale,
  input  logic              flush,
  output logic              data_sram_req,
  output logic              data_sram_wr,
  output logic [1:0]        data_sram_size,
  output logic [3:0]        data_sram_wstrb,
  output logic [ADDR_W-1:0] data_sram_addr,
  output logic [31:0]       data_sram_wdata,
  input  logic              data_sram_addr_ok,
  input  logic              data_sram_data_ok,
  input  logic [31:0]       data_sram_rdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_wr,
  output logic [1:0]        rsp_size,
  output logic [1:0]        rsp_addr_lo,
  output logic              busy
);

  localparam logic [CNT_W-1:0] MaxOcc = CNT_W'(OUTSTANDING);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  occ_q, occ_d, onbus_q, onbus_d, drop_q, drop_d;
  logic              hold_wr_q;
  logic [1:0]        hold_size_q;
  logic [ADDR_W-1:0] hold_addr_q;
  logic [31:0]       hold_wdata_q;

  logic      accept, addr_hs, dok, drop_dok, live_dok, rsp_hs, meta_empty, rsp_empty;
  req_meta_t meta_in, meta_out;
  rsp_t      rsp_in, rsp_out;

  assign req_ale       = calc_ale(req_size, req_addr[1:0]);
  assign data_sram_req = (state_q != StIdle);
  assign addr_hs       = data_sram_req & data_sram_addr_ok;
  assign req_ready     = ~flush & ~req_ale & (occ_q < MaxOcc) &
                         ((state_q == StIdle) | ((state_q == StIssue) & data_sram_addr_ok));
  assign accept        = req_valid & req_ready;

  // A data_ok with nothing on the bus is ignored so onbus can never underflow.
  assign dok      = data_sram_data_ok & ~meta_empty;
  assign drop_dok = dok & (drop_q != '0);
  assign live_dok = dok & (drop_q == '0);
  assign rsp_valid = ~rsp_empty;
  assign rsp_hs    = rsp_valid & rsp_ready;
  assign busy      = (occ_q != '0);

  assign data_sram_wr    = hold_wr_q;
  assign data_sram_size  = hold_size_q;
  assign data_sram_addr  = hold_addr_q;
  assign data_sram_wdata = hold_wdata_q;
  assign data_sram_wstrb = calc_wstrb(hold_wr_q, hold_size_q, hold_addr_q[1:0]);

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:      if (accept) state_d = StIssue;
      StIssue: begin
        if (data_sram_addr_ok) state_d = accept ? StIssue : StIdle;
        else if (flush)        state_d = StIssueKill;
      end
      StIssueKill: if (data_sram_addr_ok) state_d = StIdle;
      default:     state_d = StIdle;
    endcase
  end

  // Flush overrides the incremental update: everything still on the bus becomes dropped.
  always_comb begin
    onbus_d = onbus_q + CNT_W'(addr_hs) - CNT_W'(dok);
    if (flush) begin
      drop_d = onbus_d;
      occ_d  = onbus_d + CNT_W'(state_d == StIssueKill);
    end else begin
      drop_d = drop_q + CNT_W'(addr_hs & (state_q == StIssueKill)) - CNT_W'(drop_dok);
      occ_d  = occ_q + CNT_W'(accept) - CNT_W'(rsp_hs) - CNT_W'(drop_dok);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      occ_q   <= '0;
      onbus_q <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      occ_q   <= occ_d;
      onbus_q <= onbus_d;
      drop_q  <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_wr_q    <= 1'b0;
      hold_size_q  <= MEMSZ_B;
      hold_addr_q  <= '0;
      hold_wdata_q <= '0;
    end else if (accept) begin
      hold_wr_q    <= req_wr;
      hold_size_q  <= req_size;
      hold_addr_q  <= req_addr;
      hold_wdata_q <= align_wdata(req_size, req_wdata);
    end
  end

  // Per-access attributes ride alongside the bus so data_ok can be matched in order.
  assign meta_in = '{wr: hold_wr_q, size: hold_size_q, addr_lo: hold_addr_q[1:0]};

  rsp_fifo #(
    .WIDTH($bits(req_meta_t)),
    .DEPTH(OUTSTANDING)
  ) u_meta_fifo (
    .clk_i  (clk),
    .reset_i(reset),
    .clear_i(1'b0),
    .push_i (addr_hs),
    .wdata_i(meta_in),
    .pop_i  (dok),
    .rdata_o(meta_out),
    .empty_o(meta_empty)
  );

  assign rsp_in = '{meta: meta_out, rdata: meta_out.wr ? 32'h0 : data_sram_rdata};

  rsp_fifo #(
    .WIDTH($bits(rsp_t)),
    .DEPTH(OUTSTANDING)
  ) u_rsp_fifo (
    .clk_i  (clk),
    .reset_i(reset),
    .clear_i(flush),
    .push_i (live_dok),
    .wdata_i(rsp_in),
    .pop_i  (rsp_hs),
    .rdata_o(rsp_out),
    .empty_o(rsp_empty)
  );

  assign rsp_rdata   = rsp_out.rdata;
  assign rsp_wr      = rsp_out.meta.wr;
  assign rsp_size    = rsp_out.meta.size;
  assign rsp_addr_lo = rsp_out.meta.addr_lo;

endmodule

// File: tb/tb_data_req_queue.sv
// Self-checking bench: directed scenarios plus random traffic against a scoreboard model.
module tb_data_req_queue;

  localparam int Outstanding = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_wr, req_ale, flush;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        data_sram_req, data_sram_wr, data_sram_addr_ok, data_sram_data_ok;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr, data_sram_wdata, data_sram_rdata;
  logic        rsp_valid, rsp_ready, rsp_wr, busy;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_size, rsp_addr_lo;

  always #5 clk = ~clk;

  data_req_queue #(
    .ADDR_W     (32),
    .OUTSTANDING(Outstanding)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_wr           (req_wr),
    .req_size         (req_size),
    .req_addr         (req_addr),
    .req_wdata        (req_wdata),
    .req_ale          (req_ale),
    .flush            (flush),
    .data_sram_req    (data_sram_req),
    .data_sram_wr     (data_sram_wr),
    .data_sram_size   (data_sram_size),
    .data_sram_wstrb  (data_sram_wstrb),
    .data_sram_addr   (data_sram_addr),
    .data_sram_wdata  (data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok),
    .data_sram_data_ok(data_sram_data_ok),
    .data_sram_rdata  (data_sram_rdata),
    .rsp_valid        (rsp_valid),
    .rsp_ready        (rsp_ready),
    .rsp_rdata        (rsp_rdata),
    .rsp_wr           (rsp_wr),
    .rsp_size         (rsp_size),
    .rsp_addr_lo      (rsp_addr_lo),
    .busy             (busy)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    bit          dead;
  } bus_req_t;

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [1:0]  addr_lo;
    logic [31:0] rdata;
  } rsp_exp_t;

  bus_req_t hold_q[$];  // accepted, waiting for addr_ok
  bit       bus_q[$];   // on the bus; 1 = cancelled by flush
  rsp_exp_t exp_q[$];   // live requests in issue order
  int       fifo_cnt = 0;
  bit       mon_en   = 0;

  function automatic logic [3:0] exp_wstrb(input logic wr, input logic [1:0] sz,
                                           input logic [1:0] lo);
    if (!wr) return 4'b0000;
    if (sz == 2'd0) return 4'b0001 << lo;
    if (sz == 2'd1) return lo[1] ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [1:0] sz, input logic [31:0] d);
    if (sz == 2'd0) return {d[7:0], d[7:0], d[7:0], d[7:0]};
    if (sz == 2'd1) return {d[15:0], d[15:0]};
    return d;
  endfunction

  bus_req_t m_e;
  rsp_exp_t m_r;
  bit       m_dead;
  int       m_occ;
  bit       m_ale, m_rdy;

  always @(negedge clk) begin
    if (mon_en) begin
      m_occ = hold_q.size() + bus_q.size() + fifo_cnt;
      m_ale = (req_size == 2'd1 && req_addr[0]) || (req_size == 2'd2 && req_addr[1:0] != 2'b00);
      m_rdy = !flush && !m_ale && m_occ < Outstanding &&
              (hold_q.size() == 0 || (data_sram_addr_ok && !hold_q[0].dead));
      check_eq("req_ale", req_ale, m_ale);
      check_eq("req_ready", req_ready, m_rdy);
      check_eq("busy", busy, m_occ != 0);
      check_eq("rsp_valid", rsp_valid, fifo_cnt != 0);
      check_eq("sram_req", data_sram_req, hold_q.size() != 0);
      if (hold_q.size() != 0) begin
        check_eq("sram_addr", data_sram_addr, hold_q[0].addr);
        check_eq("sram_wr", data_sram_wr, hold_q[0].wr);
        check_eq("sram_size", data_sram_size, hold_q[0].size);
        check_eq("sram_wstrb", data_sram_wstrb, hold_q[0].wstrb);
        check_eq("sram_wdata", data_sram_wdata, hold_q[0].wdata);
      end
      if (rsp_valid && rsp_ready && !flush) begin
        if (exp_q.size() == 0) check_eq("rsp_extra", rsp_valid, 1'b0);
        else begin
          m_r = exp_q.pop_front();
          check_eq("rsp_rdata", rsp_rdata, m_r.rdata);
          check_eq("rsp_wr", rsp_wr, m_r.wr);
          check_eq("rsp_size", rsp_size, m_r.size);
          check_eq("rsp_addr_lo", rsp_addr_lo, m_r.addr_lo);
        end
        if (fifo_cnt > 0) fifo_cnt--;
      end
      if (data_sram_data_ok && bus_q.size() != 0) begin
        m_dead = bus_q.pop_front();
        if (!m_dead) begin
          if (exp_q.size() > fifo_cnt)
            exp_q[fifo_cnt].rdata = exp_q[fifo_cnt].wr ? 32'h0 : data_sram_rdata;
          fifo_cnt++;
        end
      end
      if (data_sram_req && data_sram_addr_ok && hold_q.size() != 0) begin
        m_e = hold_q.pop_front();
        bus_q.push_back(m_e.dead);
      end
      if (req_valid && req_ready) begin
        m_e.wr    = req_wr;
        m_e.size  = req_size;
        m_e.addr  = req_addr;
        m_e.wstrb = exp_wstrb(req_wr, req_size, req_addr[1:0]);
        m_e.wdata = exp_wdata(req_size, req_wdata);
        m_e.dead  = 0;
        hold_q.push_back(m_e);
        m_r.wr      = req_wr;
        m_r.size    = req_size;
        m_r.addr_lo = req_addr[1:0];
        m_r.rdata   = 32'h0;
        exp_q.push_back(m_r);
      end
      if (flush) begin
        foreach (bus_q[i]) bus_q[i] = 1;
        foreach (hold_q[i]) hold_q[i].dead = 1;
        fifo_cnt = 0;
        exp_q.delete();
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid         = 0;
    flush             = 0;
    rsp_ready         = 0;
    data_sram_addr_ok = 0;
    data_sram_data_ok = 0;
  endtask

  task automatic offer(input logic wr, input logic [1:0] sz, input logic [31:0] addr,
                       input logic [31:0] wd);
    req_valid = 1;
    req_wr    = wr;
    req_size  = sz;
    req_addr  = addr;
    req_wdata = wd;
  endtask

  task automatic drive_dok(input bit en, input logic [31:0] rd);
    data_sram_data_ok = en && bus_q.size() != 0;
    data_sram_rdata   = rd;
  endtask

  task automatic drain();
    int n = 0;
    req_valid         = 0;
    flush             = 0;
    rsp_ready         = 1;
    data_sram_addr_ok = 1;
    while (busy && n < 200) begin
      drive_dok(1, $urandom);
      step();
      n++;
    end
    if (n >= 200) check_eq("drain_timeout", busy, 1'b0);
    check_eq("drain_left", exp_q.size(), 0);
    idle_inputs();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1;
    idle_inputs();
    offer(0, 2'd0, 32'h0, 32'h0);
    req_valid       = 0;
    data_sram_rdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    reset = 0;
    #1;
    check_eq("rst_sram_req", data_sram_req, 1'b0);
    check_eq("rst_rsp_valid", rsp_valid, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_req_ready", req_ready, 1'b1);
    mon_en = 1;

    // Word load, addr_ok at T+1, data_ok at T+3, response at T+4
    offer(0, 2'd2, 32'h1C000100, 32'h0);
    step();
    req_valid = 0;
    #1;
    check_eq("t1_req", data_sram_req, 1'b1);
    check_eq("t1_addr", data_sram_addr, 32'h1C000100);
    check_eq("t1_wstrb", data_sram_wstrb, 4'b0000);
    data_sram_addr_ok = 1;
    step();
    data_sram_addr_ok = 0;
    step();
    drive_dok(1, 32'hDEADBEEF);
    #1;
    check_eq("t1_rsp_early", rsp_valid, 1'b0);
    step();
    drive_dok(0, 32'h0);
    #1;
    check_eq("t1_rsp_valid", rsp_valid, 1'b1);
    check_eq("t1_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
    check_eq("t1_rsp_wr", rsp_wr, 1'b0);
    rsp_ready = 1;
    step();
    rsp_ready = 0;

    // Half store at offset 2
    offer(1, 2'd1, 32'h1C000202, 32'h1234ABCD);
    step();
    req_valid = 0;
    #1;
    check_eq("t2_wstrb", data_sram_wstrb, 4'b1100);
    check_eq("t2_wdata", data_sram_wdata, 32'hABCDABCD);
    check_eq("t2_size", data_sram_size, 2'd1);
    drain();

    // Back-to-back issue fills the outstanding budget
    data_sram_addr_ok = 1;
    offer(0, 2'd2, 32'h1C000300, 32'h0);
    #1 check_eq("t3_rdy0", req_ready, 1'b1);
    step();
    offer(0, 2'd2, 32'h1C000304, 32'h0);
    #1 check_eq("t3_rdy1", req_ready, 1'b1);
    step();
    offer(0, 2'd2, 32'h1C000308, 32'h0);
    #1 check_eq("t3_rdy2", req_ready, 1'b0);
    step();
    #1 check_eq("t3_rdy_full", req_ready, 1'b0);
    drive_dok(1, 32'h11110000);
    step();
    drive_dok(0, 32'h0);
    #1 check_eq("t3_rsp_valid", rsp_valid, 1'b1);
    check_eq("t3_rdy_still", req_ready, 1'b0);
    rsp_ready = 1;
    step();
    rsp_ready = 0;
    #1 check_eq("t3_rdy_again", req_ready, 1'b1);
    req_valid = 0;
    drain();

    // Flush with two accesses on the bus
    data_sram_addr_ok = 1;
    offer(0, 2'd2, 32'h1C000400, 32'h0);
    step();
    offer(0, 2'd2, 32'h1C000404, 32'h0);
    step();
    req_valid = 0;
    step();
    data_sram_addr_ok = 0;
    flush = 1;
    step();
    flush = 0;
    drive_dok(1, 32'h22220000);
    step();
    drive_dok(1, 32'h33330000);
    #1 check_eq("t4_rsp_drop1", rsp_valid, 1'b0);
    check_eq("t4_busy_mid", busy, 1'b1);
    step();
    drive_dok(0, 32'h0);
    #1 check_eq("t4_rsp_drop2", rsp_valid, 1'b0);
    check_eq("t4_busy_done", busy, 1'b0);
    offer(0, 2'd0, 32'h1C000413, 32'h0);
    step();
    drain();

    // Flush while a request is still waiting for addr_ok
    offer(0, 2'd2, 32'h1C000500, 32'h0);
    step();
    req_valid = 0;
    flush = 1;
    step();
    flush = 0;
    repeat (2) begin
      #1 check_eq("t5_req_held", data_sram_req, 1'b1);
      check_eq("t5_addr_held", data_sram_addr, 32'h1C000500);
      step();
    end
    data_sram_addr_ok = 1;
    step();
    data_sram_addr_ok = 0;
    drive_dok(1, 32'hBAD0BAD0);
    step();
    drive_dok(0, 32'h0);
    #1 check_eq("t5_no_rsp", rsp_valid, 1'b0);
    check_eq("t5_idle", busy, 1'b0);

    // Misalignment boundaries
    offer(0, 2'd2, 32'h1C000606, 32'h0);
    #1 check_eq("t6_ale_w", req_ale, 1'b1);
    check_eq("t6_rdy_w", req_ready, 1'b0);
    step();
    #1 check_eq("t6_no_req", data_sram_req, 1'b0);
    offer(0, 2'd1, 32'h1C000601, 32'h0);
    #1 check_eq("t6_ale_h", req_ale, 1'b1);
    offer(0, 2'd1, 32'h1C000602, 32'h0);
    #1 check_eq("t6_ok_h", req_ale, 1'b0);
    offer(0, 2'd0, 32'h1C000603, 32'h0);
    #1 check_eq("t6_ok_b", req_ale, 1'b0);
    req_valid = 0;
    step();

    // Random traffic
    for (int c = 0; c < 1500; c++) begin
      logic [31:0] a;
      logic [1:0]  sz;
      a  = $urandom;
      sz = 2'($urandom_range(0, 2));
      if ($urandom_range(0, 7) != 0) begin
        if (sz == 2'd2) a[1:0] = 2'b00;
        if (sz == 2'd1) a[0] = 1'b0;
      end
      offer(1'($urandom_range(0, 1)), sz, a, $urandom);
      req_valid         = 1'($urandom_range(0, 1));
      flush             = ($urandom_range(0, 29) == 0);
      rsp_ready         = ($urandom_range(0, 3) != 0);
      data_sram_addr_ok = ($urandom_range(0, 2) != 0);
      drive_dok(1'($urandom_range(0, 1)), $urandom);
      step();
    end
    idle_inputs();
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
